// File: rtl/stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : stream_serializer
// Purpose  : Parallel-to-serial stage feeding a bit-serial sequence detector.
//            Accepts a NUM_BITS word over a valid/ready handshake and shifts
//            it out one bit per clock. A new word can be accepted on the
//            cycle that carries the last bit of the current word, so
//            consecutive words form one unbroken bit stream.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-high reset
//            data_in    - word to serialize, sampled on an accepted load
//            load_valid - producer has a word on data_in
//            load_ready - serializer accepts a word this cycle
//            serial_out - registered serial bit stream (IDLE_BIT when idle)
//            bit_valid  - serial_out carries a data bit
//            done       - high with the final bit of each word
//            shift_en   - (STREAM_SERIALIZER_PAUSE_EN only) 0 freezes an
//                         in-flight word; absent otherwise (treated as 1)
// Options  : define STREAM_SERIALIZER_PAUSE_EN to add the shift_en input.
// Revision : 1.0 - initial release
// ============================================================================
module stream_serializer #(
    parameter int   NUM_BITS  = 8,     // word width, 2..32
    parameter bit   SHIFT_MSB = 1'b1,  // 1: MSB first, 0: LSB first
    parameter logic IDLE_BIT  = 1'b1   // serial_out level while idle
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] data_in,
    input  logic                load_valid,
`ifdef STREAM_SERIALIZER_PAUSE_EN
    input  logic                shift_en,
`endif
    output logic                load_ready,
    output logic                serial_out,
    output logic                bit_valid,
    output logic                done
);

    localparam int                 c_CNT_W    = $clog2(NUM_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(NUM_BITS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              r_state_q,  w_state_d;
    logic [NUM_BITS-1:0] r_shreg_q,  w_shreg_d;
    logic [c_CNT_W-1:0]  r_cnt_q,    w_cnt_d;
    logic                r_serial_q, w_serial_d;

    logic                w_shift_en;
    logic                w_last;
    logic                w_accept;
    logic                w_load_first;
    logic [NUM_BITS-1:0] w_load_rem;
    logic                w_shift_first;
    logic [NUM_BITS-1:0] w_shift_rem;

`ifdef STREAM_SERIALIZER_PAUSE_EN
    assign w_shift_en = shift_en;
`else
    assign w_shift_en = 1'b1;
`endif

    // The first bit goes straight to the output register on load; the shift
    // register only holds the bits still to be sent, aligned so the next
    // one always sits at the outgoing end.
    generate
        if (SHIFT_MSB) begin : g_msb_first
            assign w_load_first  = data_in[NUM_BITS-1];
            assign w_load_rem    = data_in << 1;
            assign w_shift_first = r_shreg_q[NUM_BITS-1];
            assign w_shift_rem   = r_shreg_q << 1;
        end else begin : g_lsb_first
            assign w_load_first  = data_in[0];
            assign w_load_rem    = data_in >> 1;
            assign w_shift_first = r_shreg_q[0];
            assign w_shift_rem   = r_shreg_q >> 1;
        end
    endgenerate

    // Counter holds the number of bits still to follow the one on serial_out,
    // so zero in SHIFT means the last bit is being presented.
    assign w_last     = (r_state_q == ST_SHIFT) && (r_cnt_q == '0);
    // Ready on the last bit lets the next word follow with no gap; a paused
    // last bit must not be replaced, so readiness waits for shift_en.
    assign load_ready = (r_state_q == ST_IDLE) || (w_last && w_shift_en);
    assign w_accept   = load_ready && load_valid;

    always_comb begin
        w_state_d  = r_state_q;
        w_shreg_d  = r_shreg_q;
        w_cnt_d    = r_cnt_q;
        w_serial_d = r_serial_q;
        if (w_accept) begin
            w_state_d  = ST_SHIFT;
            w_shreg_d  = w_load_rem;
            w_cnt_d    = c_CNT_LAST;
            w_serial_d = w_load_first;
        end else if ((r_state_q == ST_SHIFT) && w_shift_en) begin
            if (w_last) begin
                w_state_d  = ST_IDLE;
                w_serial_d = IDLE_BIT;
            end else begin
                w_shreg_d  = w_shift_rem;
                w_cnt_d    = r_cnt_q - c_CNT_W'(1);
                w_serial_d = w_shift_first;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_shreg_q  <= '0;
            r_cnt_q    <= '0;
            r_serial_q <= IDLE_BIT;
        end else begin
            r_state_q  <= w_state_d;
            r_shreg_q  <= w_shreg_d;
            r_cnt_q    <= w_cnt_d;
            r_serial_q <= w_serial_d;
        end
    end

    assign serial_out = r_serial_q;
    assign bit_valid  = (r_state_q == ST_SHIFT);
    assign done       = w_last;

endmodule
`default_nettype wire

// File: doc/stream_serializer.md
Name: stream_serializer

Overview:
- Parallel-to-serial stage directly upstream of the 1101 Mealy sequence detector.
- Accepts a NUM_BITS word through a valid/ready load handshake and emits it one bit per clock on serial_out, which drives the detector's i input.
- Supports back-to-back words with no idle gap, so a detector sees contiguous streams, including patterns that span word boundaries.

Parameters:
- NUM_BITS, 8, word width; legal range 2..32.
- SHIFT_MSB, 1, 1 = MSB transmitted first, 0 = LSB transmitted first.
- IDLE_BIT, 1'b1, value driven on serial_out when no word is being shifted.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  NUM_BITS  word to serialize; sampled only on an accepted load.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  serializer can accept a word this cycle.
- serial_out  output  1  registered serial bit stream.
- bit_valid  output  1  high while serial_out carries a data bit.
- done  output  1  one-cycle pulse coincident with the last bit of a word.

Behaviour:
- Reset (async assert, synchronous release to next edge):
  - State = IDLE; serial_out = IDLE_BIT; bit_valid = 0; done = 0; bit counter = 0; shift register = 0.
  - load_ready = 1 once rst is low.
- States:
  - IDLE: load_ready = 1. On a clock edge with load_valid = 1, capture data_in into the shift register, counter = NUM_BITS-1, go to SHIFT.
  - SHIFT: each edge presents the next bit and decrements the counter.
  - When the counter reaches 0 (last bit presented), load_ready = 1 combinationally for that cycle.
    - If load_valid = 1 on that edge: reload from data_in and stay in SHIFT.
    - Otherwise: go to IDLE.
- Latency:
  - Load accepted at edge N → first bit on serial_out after edge N, valid for the cycle N..N+1.
  - Bit k of the word appears after edge N+k.
- Bit order:
  - SHIFT_MSB = 1: data_in[NUM_BITS-1] first, down to [0].
  - SHIFT_MSB = 0: data_in[0] first, up to [NUM_BITS-1].
- Outputs:
  - bit_valid = 1 exactly for the NUM_BITS cycles of each word.
  - done = 1 in the cycle serial_out carries the final bit.
  - In IDLE, serial_out returns to IDLE_BIT and bit_valid = 0.
- Back-to-back loads: no gap cycle. Bit 0 of word 2 follows the last bit of word 1 on the next edge; bit_valid stays high across the boundary.
- load_valid while load_ready = 0: ignored. The producer must hold load_valid and data_in until load_ready.
- data_in changes after acceptance: no effect on the word in flight.
- rst asserted mid-word:
  - The word in flight is discarded immediately (asynchronous).
  - All outputs take their reset values; no partial word resumes after release.
- Counter width: clog2(NUM_BITS); no wrap beyond NUM_BITS-1.

Optional Feature:
- Macro: STREAM_SERIALIZER_PAUSE_EN.
- Defined:
  - Adds input shift_en (1 bit).
  - In SHIFT with shift_en = 0: shift register, counter, serial_out, bit_valid and done all hold; load_ready = 0, including on the last bit.
  - A word in progress resumes on the first edge with shift_en = 1.
  - IDLE and load acceptance from IDLE are unaffected by shift_en.
- Not defined: port absent; behaves as shift_en tied to 1.

Test Plan:
- Power-on reset: rst = 1 for 2 cycles, then low → serial_out = 1, bit_valid = 0, done = 0, load_ready = 1, both during and after reset.
- Single word, SHIFT_MSB = 1: load 8'hD0 → serial_out = 1,1,0,1,0,0,0,0 on 8 consecutive cycles; bit_valid high exactly 8 cycles; done only on cycle 8; then serial_out = 1, load_ready = 1.
- Back-to-back: load_valid held with 8'hDD then 8'h0F → 16 contiguous bits 11011101 00001111; bit_valid never drops; done pulses on cycles 8 and 16; a downstream 1101 detector fires 2 times.
- LSB-first (SHIFT_MSB = 0): load 8'h0B → serial_out = 1,1,0,1,0,0,0,0.
- Mid-word reset: load 8'hFF, assert rst after the 3rd bit → serial_out = 1 and bit_valid = 0 immediately (before next edge); after release, load_ready = 1 and no further bits are emitted.
- With STREAM_SERIALIZER_PAUSE_EN: load 8'hD0, drop shift_en for 3 cycles after bit 2 → serial_out holds 1 and bit_valid holds 1 for those 3 cycles; the remaining bits 0,1,0,0,0,0 follow; done appears once.
